key_scan_tx: RTL and testbench

KEY_SCAN_TX -- requirements
Module: key_scan_tx

---
 rtl/key_scan_tx.sv | 164 ++++++++++++++++
 tb/tb_key_scan_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/key_scan_tx.sv
// key_scan_tx: 4x4 key matrix scanner with frame debounce, single-key
// detection and a one-deep handoff of the key's ASCII code to a UART transmitter.
module key_scan_tx #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic       tx_busy,
    output logic [7:0] data,
    output logic       tx_start,
    output logic       key_down,
    output logic       overflow
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STB_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {IDLE, HELD, BLOCKED} key_state_e;

    logic [3:0]       col_m_q, col_s_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [15:0]      frame_q, frame_d;
    logic [15:0]      prev_q, prev_d;
    logic [STB_W-1:0] stable_q, stable_d;
    key_state_e       state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             pending_q, pending_d;
    logic             start_prev_q, start_prev_d;
    logic             overflow_q, overflow_d;

    logic             row_last, frame_end, accepted, one_hot, multi, emit, start;
    logic [3:0]       key_idx;

    // Key index 0..9 map to '0'..'9', 10..15 map to 'A'..'F'.
    function automatic logic [7:0] key_code(input logic [3:0] k);
        if (k < 4'd10) return 8'h30 + {4'h0, k};
        else           return 8'h41 + ({4'h0, k} - 8'd10);
    endfunction

    // Row divider, row pointer and frame capture; the frame seen at frame end
    // includes the row being sampled on that same cycle.
    always_comb begin
        div_d     = div_q;
        row_idx_d = row_idx_q;
        frame_d   = frame_q;
        row_last  = (div_q == DIV_LAST);
        if (row_last) begin
            div_d     = '0;
            row_idx_d = row_idx_q + 2'd1;
            frame_d[int'(row_idx_q) * 4 +: 4] = ~col_s_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        frame_end = row_last && (row_idx_q == 2'd3);
    end

    // Frame-to-frame debounce: count consecutive identical frames, saturating.
    always_comb begin
        prev_d   = prev_q;
        stable_d = stable_q;
        if (frame_end) begin
            prev_d = frame_d;
            if (frame_d == prev_q)
                stable_d = (stable_q == STB_MAX) ? stable_q : stable_q + STB_W'(1);
            else
                stable_d = '0;
        end
        accepted = frame_end && (stable_d == STB_MAX);
    end

    // Locate the pressed key and classify the frame as single or multi key.
    always_comb begin
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_d[i]) key_idx = 4'(i);
        end
        one_hot = $onehot(frame_d);
        multi   = (frame_d != 16'h0) && !one_hot;
    end

    // Key FSM: a new code is emitted only on an IDLE -> HELD transition.
    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accepted && one_hot) begin
                    state_d = HELD;
                    emit    = 1'b1;
                end else if (accepted && multi) begin
                    state_d = BLOCKED;
                end
            end
            HELD, BLOCKED: begin
                if (accepted && (frame_d == 16'h0)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handoff to the UART: start is combinational from the pending flag so an
    // emit in the start cycle can refill data/pending on the closing edge
    // without touching data while tx_start is visible.
    always_comb begin
        start        = pending_q && !tx_busy && !start_prev_q && !rst;
        start_prev_d = start;
        pending_d    = pending_q;
        data_d       = data_q;
        overflow_d   = 1'b0;
        if (start) pending_d = 1'b0;
        if (emit) begin
            if (pending_q && !start) begin
                overflow_d = 1'b1;
            end else begin
                data_d    = key_code(key_idx);
                pending_d = 1'b1;
            end
        end
    end

    // All state registers, including the two-flop column synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_m_q      <= '0;
            col_s_q      <= '0;
            div_q        <= '0;
            row_idx_q    <= '0;
            frame_q      <= '0;
            prev_q       <= '0;
            stable_q     <= '0;
            state_q      <= IDLE;
            data_q       <= '0;
            pending_q    <= 1'b0;
            start_prev_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            col_m_q      <= col;
            col_s_q      <= col_m_q;
            div_q        <= div_d;
            row_idx_q    <= row_idx_d;
            frame_q      <= frame_d;
            prev_q       <= prev_d;
            stable_q     <= stable_d;
            state_q      <= state_d;
            data_q       <= data_d;
            pending_q    <= pending_d;
            start_prev_q <= start_prev_d;
            overflow_q   <= overflow_d;
        end
    end

    assign row      = ~(4'b0001 << row_idx_q);
    assign data     = data_q;
    assign tx_start = start;
    assign key_down = (state_q == HELD);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_key_scan_tx.sv
// Testbench for key_scan_tx: a simulated key matrix drives the columns from
// the DUT's row drive; expected codes come from the key-to-ASCII rule.
module tb_key_scan_tx;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam int SETTLE   = 8 * FRAME;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col;
    logic [3:0] row;
    logic       tx_busy = 1'b0;
    logic [7:0] data;
    logic       tx_start;
    logic       key_down;
    logic       overflow;

    logic [15:0] pressed = 16'h0;

    int n_tests = 0;
    int n_fail  = 0;
    int tx_cnt  = 0;
    int ovf_cnt = 0;
    logic [7:0] last_tx_data = 8'h00;

    key_scan_tx #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DEB)) dut (
        .clk(clk), .rst(rst), .col(col), .row(row), .tx_busy(tx_busy),
        .data(data), .tx_start(tx_start), .key_down(key_down), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4 + c] && !row[r]) col[c] = 1'b0;
    end

    // Observe handoff pulses.
    always @(negedge clk) begin
        if (tx_start) begin
            tx_cnt       = tx_cnt + 1;
            last_tx_data = data;
        end
        if (overflow) ovf_cnt = ovf_cnt + 1;
    end

    function automatic logic [7:0] ascii_of(input int k);
        if (k < 10) return 8'(48 + k);
        return 8'(65 + k - 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_row"}, 32'(row), 32'h0E);
        chk({tag, "_data"}, 32'(data), 32'h00);
        chk({tag, "_txs"}, 32'(tx_start), 32'h0);
        chk({tag, "_kd"}, 32'(key_down), 32'h0);
        chk({tag, "_ovf"}, 32'(overflow), 32'h0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int k;
        int obase;

        // Reset values.
        cycles(3);
        chk_reset_outputs("reset");

        // Row sequence after reset release, each value held SCAN_DIV cycles.
        rst = 1'b0;
        #1;
        chk("row_seq0", 32'(row), 32'h0E);
        for (int i = 1; i < 4 * FRAME / 4 * 1 + 0; i++) begin
            @(negedge clk);
            chk($sformatf("row_seq%0d", i), 32'(row), 32'(~(4'b0001 << (i / SCAN_DIV)) & 4'hF));
        end

        // Clean presses: key 5 first, then random keys.
        for (int t = 0; t < 4; t++) begin
            k = (t == 0) ? 5 : int'($urandom_range(0, 15));
            cycles(int'($urandom_range(0, FRAME - 1)));
            base = tx_cnt;
            pressed = 16'(1 << k);
            cycles(SETTLE);
            chk($sformatf("press%0d_txcnt", k), 32'(tx_cnt - base), 32'd1);
            chk($sformatf("press%0d_code", k), 32'(last_tx_data), 32'(ascii_of(k)));
            chk($sformatf("press%0d_data", k), 32'(data), 32'(ascii_of(k)));
            chk($sformatf("press%0d_kd", k), 32'(key_down), 32'h1);
            pressed = 16'h0;
            cycles(SETTLE);
            chk($sformatf("rel%0d_kd", k), 32'(key_down), 32'h0);
            chk($sformatf("rel%0d_txcnt", k), 32'(tx_cnt - base), 32'd1);
        end

        // Key 12 bouncing once per frame for three frames, then held.
        cycles(int'($urandom_range(0, FRAME - 1)));
        base = tx_cnt;
        pressed = 16'(1 << 12);
        cycles(FRAME);
        pressed = 16'h0;
        cycles(FRAME);
        pressed = 16'(1 << 12);
        cycles(FRAME);
        chk("bounce_no_tx", 32'(tx_cnt - base), 32'd0);
        chk("bounce_no_kd", 32'(key_down), 32'h0);
        cycles(SETTLE);
        chk("bounce_txcnt", 32'(tx_cnt - base), 32'd1);
        chk("bounce_code", 32'(last_tx_data), 32'h43);
        pressed = 16'h0;
        cycles(SETTLE);

        // Keys 0 and 15 together block until an all-zero frame is accepted.
        base = tx_cnt;
        pressed = 16'h8001;
        cycles(SETTLE);
        chk("multi_no_tx", 32'(tx_cnt - base), 32'd0);
        chk("multi_kd", 32'(key_down), 32'h0);
        pressed = 16'h0001;
        cycles(SETTLE);
        chk("blocked_no_tx", 32'(tx_cnt - base), 32'd0);
        chk("blocked_kd", 32'(key_down), 32'h0);
        pressed = 16'h0;
        cycles(SETTLE);
        pressed = 16'(1 << 7);
        cycles(SETTLE);
        chk("unblock_txcnt", 32'(tx_cnt - base), 32'd1);
        chk("unblock_code", 32'(last_tx_data), 32'h37);
        chk("unblock_kd", 32'(key_down), 32'h1);
        pressed = 16'h0;
        cycles(SETTLE);

        // Busy downstream: first code waits, second is dropped with overflow.
        base  = tx_cnt;
        obase = ovf_cnt;
        tx_busy = 1'b1;
        pressed = 16'(1 << 1);
        cycles(SETTLE);
        pressed = 16'h0;
        cycles(SETTLE);
        pressed = 16'(1 << 2);
        cycles(SETTLE);
        pressed = 16'h0;
        cycles(SETTLE);
        chk("busy_no_tx", 32'(tx_cnt - base), 32'd0);
        chk("busy_ovf", 32'(ovf_cnt - obase), 32'd1);
        chk("busy_data", 32'(data), 32'h31);
        tx_busy = 1'b0;
        cycles(6);
        chk("busy_txcnt", 32'(tx_cnt - base), 32'd1);
        chk("busy_code", 32'(last_tx_data), 32'h31);
        cycles(SETTLE);
        chk("busy_single", 32'(tx_cnt - base), 32'd1);

        // Reset while a code is pending discards it.
        tx_busy = 1'b1;
        pressed = 16'(1 << 9);
        cycles(SETTLE);
        chk("pend_data", 32'(data), 32'h39);
        base = tx_cnt;
        pressed = 16'h0;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        tx_busy = 1'b0;
        cycles(SETTLE);
        chk("postrst_no_tx", 32'(tx_cnt - base), 32'd0);
        chk("postrst_data", 32'(data), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
